// File: rtl/seq_divider_16by8.sv
// Sequential restoring unsigned divider: 16-bit dividend by 8-bit divisor, one quotient bit per clock.
// Single start/done handshake; a zero divisor finishes immediately with div_by_zero set.
module seq_divider_16by8 #(
  parameter int unsigned DIVIDEND_W = 16,
  parameter int unsigned DIVISOR_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int unsigned CNT_W = $clog2(DIVIDEND_W + 1);
  localparam int unsigned TRY_W = DIVISOR_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0] work_q, work_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic [DIVISOR_W-1:0]  dvsr_q, dvsr_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [DIVIDEND_W-1:0] quotient_q, quotient_d;
  logic [DIVISOR_W-1:0]  remainder_q, remainder_d;
  logic                  dz_q, dz_d;

  logic [TRY_W-1:0]      shifted_c;
  logic [TRY_W-1:0]      trial_c;
  logic                  neg_c;

  // The restored remainder is always below the divisor, so the shifted value fits in TRY_W bits
  // and the trial difference stays within signed TRY_W range; its MSB is the sign.
  always_comb begin
    shifted_c = {rem_q, work_q[DIVIDEND_W-1]};
    trial_c   = shifted_c - TRY_W'(dvsr_q);
    neg_c     = trial_c[TRY_W-1];
  end

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    work_d      = work_q;
    rem_d       = rem_q;
    dvsr_d      = dvsr_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dz_d        = dz_q;

    case (state_q)
      IDLE, FIN: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        if (start) begin
          if (divisor == '0) begin
            state_d     = FIN;
            done_d      = 1'b1;
            quotient_d  = '1;
            remainder_d = '0;
            dz_d        = 1'b1;
          end else begin
            state_d = CALC;
            busy_d  = 1'b1;
            work_d  = dividend;
            dvsr_d  = divisor;
            rem_d   = '0;
            cnt_d   = CNT_W'(DIVIDEND_W);
          end
        end
      end
      CALC: begin
        work_d = {work_q[DIVIDEND_W-2:0], ~neg_c};
        rem_d  = neg_c ? shifted_c[DIVISOR_W-1:0] : trial_c[DIVISOR_W-1:0];
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d     = FIN;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          quotient_d  = work_d;
          remainder_d = rem_d;
          dz_d        = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      work_q      <= '0;
      rem_q       <= '0;
      dvsr_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dz_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      work_q      <= work_d;
      rem_q       <= rem_d;
      dvsr_q      <= dvsr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dz_q        <= dz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dz_q;

endmodule

// File: tb/tb_seq_divider_16by8.sv
// Self-checking bench for seq_divider_16by8: directed vector table, multi-cycle corner sequences,
// and random operands, with results scored through an expected-result queue.
module tb_seq_divider_16by8;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  seq_divider_16by8 #(.DIVIDEND_W(16), .DIVISOR_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;
  } exp_t;

  typedef struct {
    logic [15:0] dvd;
    logic [7:0]  dvs;
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;
    int          lat;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [15:0] dvd, input logic [7:0] dvs);
    exp_t e;
    if (dvs == 8'd0) begin
      e.q = 16'hFFFF; e.r = 8'd0; e.dz = 1'b1;
    end else begin
      e.q = dvd / 16'(dvs); e.r = 8'(dvd % 16'(dvs)); e.dz = 1'b0;
    end
    return e;
  endfunction

  // Called just after a posedge; start is sampled on the next posedge.
  task automatic drive(input logic [15:0] dvd, input logic [7:0] dvs, input bit push, input exp_t e);
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    if (push) sb.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Waits (bounded) for done, checking latency and that busy is high exactly before done.
  task automatic wait_done(input string name, input int lat);
    int  k;
    int  bad;
    bit  seen;
    k = 0; bad = 0; seen = 1'b0;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      if (busy !== ((k < lat) ? 1'b1 : 1'b0)) bad++;
      if (done === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no done within %0d cycles, required at %0d", name, k, lat);
    end else begin
      check({name, "_latency"}, 32'(k), 32'(lat));
    end
    check({name, "_busy"}, 32'(bad), 32'd0);
  endtask

  // Scoreboard monitor: every done pops one expected result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("quotient", 32'(quotient), 32'(e.q));
          check("remainder", 32'(remainder), 32'(e.r));
          check("div_by_zero", 32'(div_by_zero), 32'(e.dz));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    exp_t e;
    int   seen;
    logic [15:0] rd;
    logic [7:0]  rv;

    vecs[0] = '{16'd28743, 8'd201, 16'd143,   8'd0, 1'b0, 17};
    vecs[1] = '{16'd1000,  8'd7,   16'd142,   8'd6, 1'b0, 17};
    vecs[2] = '{16'd65535, 8'd1,   16'd65535, 8'd0, 1'b0, 17};
    vecs[3] = '{16'd5,     8'd255, 16'd0,     8'd5, 1'b0, 17};
    vecs[4] = '{16'd65535, 8'd255, 16'd257,   8'd0, 1'b0, 17};
    vecs[5] = '{16'd100,   8'd0,   16'hFFFF,  8'd0, 1'b1, 1};
    vecs[6] = '{16'd10,    8'd3,   16'd3,     8'd1, 1'b0, 17};

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_div_by_zero", 32'(div_by_zero), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      e = '{vecs[i].q, vecs[i].r, vecs[i].dz};
      drive(vecs[i].dvd, vecs[i].dvs, 1'b1, e);
      wait_done($sformatf("vec%0d", i), vecs[i].lat);
      @(posedge clk);
      #1;
    end

    // Start pulses while busy are ignored; start held through FIN is accepted back-to-back.
    drive(16'd1000, 8'd7, 1'b1, '{16'd142, 8'd6, 1'b0});
    repeat (2) @(posedge clk);
    #1;
    drive(16'd500, 8'd3, 1'b0, e);
    repeat (5) @(posedge clk);
    #1;
    drive(16'd9999, 8'd0, 1'b0, e);
    repeat (6) @(posedge clk);
    #1;
    dividend = 16'd50; divisor = 8'd5; start = 1'b1;
    sb.push_back('{16'd10, 8'd0, 1'b0});
    wait_done("ignored_start", 2);
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("back_to_back", 17);
    @(posedge clk);
    #1;

    // Reset at cycle 8 of an operation aborts it silently.
    drive(16'd28743, 8'd201, 1'b0, e);
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_quotient", 32'(quotient), 32'd0);
    check("abort_remainder", 32'(remainder), 32'd0);
    check("abort_div_by_zero", 32'(div_by_zero), 32'd0);
    seen = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    check("abort_no_done", 32'(seen), 32'd0);
    @(posedge clk);
    #1;
    drive(16'd28743, 8'd201, 1'b1, '{16'd143, 8'd0, 1'b0});
    wait_done("after_abort", 17);
    @(posedge clk);
    #1;

    for (int n = 0; n < 2000; n++) begin
      rd = 16'($urandom);
      rv = 8'($urandom_range(1, 255));
      drive(rd, rv, 1'b1, model(rd, rv));
      wait_done("rand", 17);
      check("rand_rem_lt_div", 32'(remainder < rv), 32'd1);
      @(posedge clk);
      #1;
    end

    repeat (3) @(posedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
